// File: rtl/vco_band_cal_if.sv
// rtl/vco_band_cal_if.sv - control/status bundle between the calibration engine and its host
interface vco_band_cal_if;
    logic        start;
    logic        abort;
    logic        fb_pulse;
    logic [15:0] target;
    logic [5:0]  cfs;
    logic        vctl_hold;
    logic        busy;
    logic        done;
    logic [15:0] meas_cnt;

    modport master (
        output start, abort, fb_pulse, target,
        input  cfs, vctl_hold, busy, done, meas_cnt
    );

    modport slave (
        input  start, abort, fb_pulse, target,
        output cfs, vctl_hold, busy, done, meas_cnt
    );
endinterface

// File: rtl/vco_band_cal.sv
// rtl/vco_band_cal.sv - binary-search VCO coarse band calibration against a target pulse count
module vco_band_cal #(
    parameter int WIN    = 256,
    parameter int SETTLE = 16
) (
    input  logic          clk,
    input  logic          rst,
    vco_band_cal_if.slave cal_if
);
    localparam logic [2:0] S_IDLE    = 3'd0;
    localparam logic [2:0] S_SETTLE  = 3'd1;
    localparam logic [2:0] S_MEASURE = 3'd2;
    localparam logic [2:0] S_DECIDE  = 3'd3;
    localparam logic [2:0] S_DONE    = 3'd4;

    localparam logic [15:0] SETTLE_LAST = 16'(SETTLE - 1);
    localparam logic [15:0] WIN_LAST    = 16'(WIN - 1);

    logic [2:0]  r_state;
    logic [5:0]  r_cfs;
    logic [2:0]  r_idx;
    logic        r_busy;
    logic        r_done;
    logic [15:0] r_meas;
    logic [15:0] r_win_cnt;
    logic [15:0] r_tmr;

    logic        w_active;
    logic        w_accept;
    logic        w_abort;
    logic        w_too_fast;
    logic [5:0]  w_cfs_dec;

    assign w_active   = (r_state == S_SETTLE) || (r_state == S_MEASURE) || (r_state == S_DECIDE);
    assign w_abort    = cal_if.abort && w_active;
    // abort beats start even when abort itself has nothing to cancel
    assign w_accept   = cal_if.start && !cal_if.abort &&
                        ((r_state == S_IDLE) || (r_state == S_DONE));
    assign w_too_fast = r_win_cnt > cal_if.target;

    always_comb begin
        w_cfs_dec = r_cfs;
        if (w_too_fast)
            w_cfs_dec[r_idx] = 1'b0;
        if (r_idx != 3'd0)
            w_cfs_dec[r_idx - 3'd1] = 1'b1;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state   <= S_IDLE;
            r_cfs     <= 6'b100000;
            r_idx     <= 3'd5;
            r_busy    <= 1'b0;
            r_done    <= 1'b0;
            r_meas    <= 16'd0;
            r_win_cnt <= 16'd0;
            r_tmr     <= 16'd0;
        end else if (w_abort) begin
            r_state <= S_IDLE;
            r_busy  <= 1'b0;
            r_done  <= 1'b0;
        end else if (w_accept) begin
            r_state <= S_SETTLE;
            r_cfs   <= 6'b100000;
            r_idx   <= 3'd5;
            r_busy  <= 1'b1;
            r_done  <= 1'b0;
            r_tmr   <= 16'd0;
        end else begin
            case (r_state)
                S_SETTLE: begin
                    if (r_tmr == SETTLE_LAST) begin
                        r_tmr     <= 16'd0;
                        r_win_cnt <= 16'd0;
                        r_state   <= S_MEASURE;
                    end else begin
                        r_tmr <= r_tmr + 16'd1;
                    end
                end
                S_MEASURE: begin
                    if (cal_if.fb_pulse && (r_win_cnt != 16'hFFFF))
                        r_win_cnt <= r_win_cnt + 16'd1;
                    if (r_tmr == WIN_LAST) begin
                        r_tmr   <= 16'd0;
                        r_state <= S_DECIDE;
                    end else begin
                        r_tmr <= r_tmr + 16'd1;
                    end
                end
                S_DECIDE: begin
                    r_meas <= r_win_cnt;
                    r_cfs  <= w_cfs_dec;
                    if (r_idx == 3'd0) begin
                        r_state <= S_DONE;
                        r_busy  <= 1'b0;
                        r_done  <= 1'b1;
                    end else begin
                        r_idx   <= r_idx - 3'd1;
                        r_state <= S_SETTLE;
                    end
                end
                S_IDLE, S_DONE: r_state <= r_state;
                default:        r_state <= S_IDLE;
            endcase
        end
    end

    assign cal_if.cfs       = r_cfs;
    assign cal_if.vctl_hold = r_busy;
    assign cal_if.busy      = r_busy;
    assign cal_if.done      = r_done;
    assign cal_if.meas_cnt  = r_meas;
endmodule

// File: tb/tb_vco_band_cal.sv
// tb/tb_vco_band_cal.sv - scoreboard bench for vco_band_cal with a linear VCO plant model
module tb_vco_band_cal;
    localparam int WIN = 256;
    localparam int SET = 16;
    localparam int PER = SET + WIN + 1;
    localparam int LAT = 6 * PER;

    typedef struct {
        logic [5:0]  cfs;
        logic [15:0] meas;
        int          lat;
        int          busy_len;
    } exp_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   n_cmp = 0;
    int   n_bad = 0;
    int   cyc = 0;
    int   t0 = 0;
    bit   gen_on = 1'b0;
    exp_t sb[$];

    vco_band_cal_if bus ();

    vco_band_cal #(.WIN(WIN), .SETTLE(SET)) dut (
        .clk    (clk),
        .rst    (rst),
        .cal_if (bus)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, got, exp, $time);
        end
    endtask

    // pulses per window from the linear plant, limited by the window length
    function automatic int rate(input logic [5:0] c);
        int n;
        n = 100 + 4 * int'(c);
        return (n > WIN) ? WIN : n;
    endfunction

    function automatic exp_t model(input logic [15:0] tgt);
        exp_t e;
        logic [5:0] c;
        int m;
        c = 6'b100000;
        m = 0;
        for (int i = 5; i >= 0; i--) begin
            m = rate(c);
            if (m > int'(tgt)) c[i] = 1'b0;
            if (i > 0) c[i-1] = 1'b1;
        end
        e.cfs = c;
        e.meas = 16'(m);
        e.lat = LAT;
        e.busy_len = LAT;
        return e;
    endfunction

    // plant: first rate(cfs) cycles of each measurement window carry a pulse
    initial begin
        int j, p;
        bus.fb_pulse = 1'b0;
        forever begin
            @(negedge clk);
            j = cyc - t0;
            p = j % PER;
            if (gen_on && j >= 0 && j < LAT && p >= SET && p < SET + WIN && (p - SET) < rate(bus.cfs))
                bus.fb_pulse = 1'b1;
            else
                bus.fb_pulse = 1'b0;
        end
    end

    initial begin
        int run;
        bit pd;
        exp_t e;
        run = 0;
        pd = 1'b0;
        forever begin
            @(negedge clk);
            check("hold_eq_busy", bus.vctl_hold, bus.busy);
            if (rst) begin
                run = 0;
                pd = 1'b0;
            end else begin
                if (bus.busy) run++;
                if (bus.done && !pd) begin
                    if (sb.size() == 0) begin
                        check("unexpected_done", 1, 0);
                    end else begin
                        e = sb.pop_front();
                        check("cfs", bus.cfs, e.cfs);
                        check("meas_cnt", bus.meas_cnt, e.meas);
                        check("latency", cyc - t0, e.lat);
                        check("busy_len", run, e.busy_len);
                    end
                end
                if (!bus.busy) run = 0;
                pd = bus.done;
            end
        end
    end

    task automatic start_cal(input logic [15:0] tgt, input bit push);
        @(negedge clk);
        bus.target = tgt;
        bus.start = 1'b1;
        @(posedge clk);
        #1;
        t0 = cyc;
        gen_on = 1'b1;
        if (push) sb.push_back(model(tgt));
        @(negedge clk);
        bus.start = 1'b0;
    endtask

    task automatic wait_done();
        int k;
        k = 0;
        while (sb.size() != 0 && k < LAT + 100) begin
            @(negedge clk);
            #1;
            k++;
        end
        check("done_timeout", sb.size(), 0);
        gen_on = 1'b0;
    endtask

    task automatic wait_phase(input int goal);
        int k;
        k = 0;
        while ((cyc - t0) != goal && k < LAT + 100) begin
            @(negedge clk);
            k++;
        end
        check("phase_reach", cyc - t0, goal);
    endtask

    initial begin
        bus.start = 1'b0;
        bus.abort = 1'b0;
        bus.target = 16'd0;
        rst = 1'b1;
        repeat (3) @(negedge clk);
        check("rst_cfs", bus.cfs, 6'b100000);
        check("rst_busy", bus.busy, 0);
        check("rst_hold", bus.vctl_hold, 0);
        check("rst_done", bus.done, 0);
        check("rst_meas", bus.meas_cnt, 0);
        rst = 1'b0;
        @(negedge clk);
        check("idle_busy", bus.busy, 0);

        bus.start = 1'b1;
        bus.abort = 1'b1;
        @(negedge clk);
        bus.start = 1'b0;
        bus.abort = 1'b0;
        check("start_abort_idle_busy", bus.busy, 0);
        @(negedge clk);
        check("start_abort_idle_busy2", bus.busy, 0);

        start_cal(16'd228, 1'b1);
        wait_done();

        start_cal(16'd0, 1'b1);
        check("restart_done_drop", bus.done, 0);
        check("restart_busy", bus.busy, 1);
        check("restart_cfs", bus.cfs, 6'b100000);
        wait_done();

        start_cal(16'hFFFF, 1'b1);
        repeat (500) @(negedge clk);
        bus.start = 1'b1;
        @(negedge clk);
        bus.start = 1'b0;
        check("start_while_busy", bus.busy, 1);
        wait_done();

        bus.abort = 1'b1;
        @(negedge clk);
        bus.abort = 1'b0;
        check("abort_in_done_done", bus.done, 1);
        check("abort_in_done_cfs", bus.cfs, 6'd63);
        bus.start = 1'b1;
        bus.abort = 1'b1;
        @(negedge clk);
        bus.start = 1'b0;
        bus.abort = 1'b0;
        check("start_abort_done_done", bus.done, 1);
        check("start_abort_done_busy", bus.busy, 0);

        start_cal(16'd227, 1'b1);
        wait_done();

        start_cal(16'd228, 1'b0);
        wait_phase(2 * PER + SET + 10);
        bus.abort = 1'b1;
        @(negedge clk);
        bus.abort = 1'b0;
        check("abort_busy", bus.busy, 0);
        check("abort_hold", bus.vctl_hold, 0);
        check("abort_done", bus.done, 0);
        check("abort_cfs", bus.cfs, 6'b101000);
        check("abort_meas", bus.meas_cnt, rate(6'b110000));
        repeat (3) @(negedge clk);
        check("abort_stays_idle", bus.busy, 0);
        gen_on = 1'b0;

        start_cal(16'd227, 1'b0);
        wait_phase(PER + SET + 50);
        #2;
        rst = 1'b1;
        #1;
        check("async_rst_cfs", bus.cfs, 6'b100000);
        check("async_rst_busy", bus.busy, 0);
        check("async_rst_hold", bus.vctl_hold, 0);
        check("async_rst_done", bus.done, 0);
        check("async_rst_meas", bus.meas_cnt, 0);
        gen_on = 1'b0;
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        check("post_rst_idle", bus.busy, 0);

        start_cal(16'd227, 1'b1);
        wait_done();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
